// File: rtl/bias_loader_pkg.sv
// Shared definitions for the bias loader: FSM state encodings and a
// constant-evaluable ceil(log2) used to size the word counters.
package bias_loader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

    // Returns the number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_loader_if.sv
// ROM read port and bias-buffer write port of the bias loader, bundled as one bus.
interface bias_loader_if #(
    parameter int BW     = 16,
    parameter int ADDR_W = 8
);
    logic                     o_rom_en;
    logic [ADDR_W-1:0]        o_rom_addr;
    logic signed [BW-1:0]     i_rom_data;
    logic signed [BW-1:0]     o_data;
    logic                     o_valid;

    modport master (
        output o_rom_en,
        output o_rom_addr,
        input  i_rom_data,
        output o_data,
        output o_valid
    );

    modport slave (
        input  o_rom_en,
        input  o_rom_addr,
        output i_rom_data,
        input  o_data,
        input  o_valid
    );
endinterface

// File: rtl/bias_rd_pipe.sv
// Tracks outstanding ROM reads: an RD_LAT-deep shift register of the read
// enable whose tail marks the cycle in which the ROM data is valid.
module bias_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    output logic tail_o
);
    logic [RD_LAT-1:0] sr_q;
    logic [RD_LAT-1:0] sr_d;

    generate
        if (RD_LAT == 1) begin : g_one
            assign sr_d = en_i;
        end else begin : g_many
            assign sr_d = {sr_q[RD_LAT-2:0], en_i};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign tail_o = sr_q[RD_LAT-1];
endmodule

// File: rtl/bias_loader.sv
// Bias loader: reads SIZE words from a fixed-latency ROM starting at BASE_ADDR
// and strobes them into the bias buffer in address order.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int BW        = 16,
    parameter int SIZE      = 10,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          ce,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    bias_loader_if.master bus
);
    localparam int                CNT_W      = clog2(SIZE + 1);
    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(SIZE);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     ret_cnt_q, ret_cnt_d;
    logic signed [BW-1:0] data_q, data_d;
    logic                 valid_q;
    logic                 rom_en;
    logic                 tail;

    bias_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .clr_i  (global_rst),
        .en_i   (rom_en),
        .tail_o (tail)
    );

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rom_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && ce) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ce) begin
                    rom_en      = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == LAST_ISSUE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ret_cnt_q == CNT_FULL) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Rewinding here puts the address back at BASE for the IDLE cycle.
                state_d     = S_IDLE;
                issue_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Return path runs regardless of ce so every issued read lands.
    always_comb begin
        ret_cnt_d = tail ? ret_cnt_q + CNT_W'(1) : ret_cnt_q;
        data_d    = tail ? bus.i_rom_data : data_q;
        if (state_q == S_DONE) begin
            ret_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            data_q      <= data_d;
            valid_q     <= tail;
        end
    end

    assign bus.o_rom_en   = rom_en;
    assign bus.o_rom_addr = BASE + ADDR_W'(issue_cnt_q);
    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign o_busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign o_done         = (state_q == S_DONE);
endmodule

// File: tb/tb_bias_loader.sv
// Bench for bias_loader: three instances (basic, long latency, single word)
// checked every cycle against a transaction-level model plus literal checkpoints.
`timescale 1ns/1ps
module tb_bias_loader;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic [N-1:0] start;
    wire  [N-1:0] busy_w;
    wire  [N-1:0] done_w;
    wire  [N-1:0] en_w;
    wire  [N-1:0] valid_w;
    wire  [7:0]   addr_w [N];
    wire  signed [15:0] data_w [N];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    bias_loader_if #(.BW(16), .ADDR_W(8)) bus0 ();
    bias_loader_if #(.BW(16), .ADDR_W(8)) bus1 ();
    bias_loader_if #(.BW(16), .ADDR_W(8)) bus2 ();

    bias_loader #(.BW(16), .SIZE(10), .ADDR_W(8), .BASE_ADDR(32'h20), .RD_LAT(1)) u_dut0 (
        .clk(clk), .global_rst(rst), .ce(ce), .i_start(start[0]),
        .o_busy(busy_w[0]), .o_done(done_w[0]), .bus(bus0.master));
    bias_loader #(.BW(16), .SIZE(4), .ADDR_W(8), .BASE_ADDR(32'h40), .RD_LAT(3)) u_dut1 (
        .clk(clk), .global_rst(rst), .ce(ce), .i_start(start[1]),
        .o_busy(busy_w[1]), .o_done(done_w[1]), .bus(bus1.master));
    bias_loader #(.BW(16), .SIZE(1), .ADDR_W(8), .BASE_ADDR(32'h05), .RD_LAT(1)) u_dut2 (
        .clk(clk), .global_rst(rst), .ce(ce), .i_start(start[2]),
        .o_busy(busy_w[2]), .o_done(done_w[2]), .bus(bus2.master));

    assign en_w[0] = bus0.o_rom_en;   assign addr_w[0] = bus0.o_rom_addr;
    assign en_w[1] = bus1.o_rom_en;   assign addr_w[1] = bus1.o_rom_addr;
    assign en_w[2] = bus2.o_rom_en;   assign addr_w[2] = bus2.o_rom_addr;
    assign valid_w[0] = bus0.o_valid; assign data_w[0] = bus0.o_data;
    assign valid_w[1] = bus1.o_valid; assign data_w[1] = bus1.o_data;
    assign valid_w[2] = bus2.o_valid; assign data_w[2] = bus2.o_data;

    function automatic int p_size(input int k);
        return (k == 0) ? 10 : (k == 1) ? 4 : 1;
    endfunction
    function automatic int p_lat(input int k);
        return (k == 1) ? 3 : 1;
    endfunction
    function automatic int p_base(input int k);
        return (k == 0) ? 32'h20 : (k == 1) ? 32'h40 : 32'h05;
    endfunction
    function automatic logic signed [15:0] rom_word(input int k, input logic [7:0] a);
        if (k == 0) return 16'(int'(a) - 32 + 100);
        if (k == 1) return 16'(-500 - int'(a));
        return -16'sd1234;
    endfunction

    // ROM with RD_LAT-cycle read latency; unread slots carry a filler pattern.
    logic signed [15:0] romq [N][4];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            for (int s = 3; s > 0; s--) romq[k][s] <= romq[k][s-1];
            romq[k][0] <= en_w[k] ? rom_word(k, addr_w[k]) : 16'sh5A5A;
        end
    end
    assign bus0.i_rom_data = romq[0][0];
    assign bus1.i_rom_data = romq[1][2];
    assign bus2.i_rom_data = romq[2][0];

    // Transaction model: a word issued in cycle c is strobed in c+RD_LAT+1.
    bit   m_busy [N], m_issuing [N], m_done [N], m_valid [N];
    int   m_issued [N], m_ret [N];
    logic signed [15:0] m_data [N];
    int   pc [N][16];
    logic [7:0] pa [N][16];
    int   ph [N], pt [N];

    always @(posedge clk) begin
        bit nv, nd, acc;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_issuing[k] = 0; m_done[k] = 0; m_valid[k] = 0;
                m_issued[k] = 0; m_ret[k] = 0; m_data[k] = '0; ph[k] = 0; pt[k] = 0;
            end else begin
                nv = 0;
                if (ph[k] != pt[k] && pc[k][ph[k]] == cyc - p_lat(k)) begin
                    nv = 1;
                    m_data[k] = rom_word(k, pa[k][ph[k]]);
                    ph[k] = (ph[k] + 1) % 16;
                end
                if (m_issuing[k] && ce) begin
                    pc[k][pt[k]] = cyc;
                    pa[k][pt[k]] = 8'(p_base(k) + m_issued[k]);
                    pt[k] = (pt[k] + 1) % 16;
                    m_issued[k]++;
                    if (m_issued[k] == p_size(k)) m_issuing[k] = 0;
                end
                nd  = m_busy[k] && m_valid[k] && (m_ret[k] == p_size(k));
                acc = !m_busy[k] && !m_done[k] && start[k] && ce;
                if (nv) m_ret[k]++;
                if (acc) begin
                    m_issuing[k] = 1; m_issued[k] = 0; m_ret[k] = 0;
                end
                m_busy[k]  = acc || (m_busy[k] && !nd);
                m_valid[k] = nv;
                m_done[k]  = nd;
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input int k, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // Event trackers for literal checkpoints.
    int cnt_en [N], cnt_v [N], cnt_done [N], cnt_busy [N];
    int t_first_en [N], t_first_v [N], t_last_v [N], t_done [N];
    int en_cyc [N][16];
    int slot [N][16];

    task automatic clear_trk();
        for (int k = 0; k < N; k++) begin
            cnt_en[k] = 0; cnt_v[k] = 0; cnt_done[k] = 0; cnt_busy[k] = 0;
            t_first_en[k] = -1; t_first_v[k] = -1; t_last_v[k] = -1; t_done[k] = -1;
            for (int i = 0; i < 16; i++) begin
                en_cyc[k][i] = -1; slot[k][i] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < N; k++) begin
                chk("rom_en", k, int'(en_w[k]), int'(m_issuing[k] && ce));
                if (m_issuing[k])
                    chk("rom_addr", k, int'(addr_w[k]), p_base(k) + m_issued[k]);
                else if (!m_busy[k] && !m_done[k])
                    chk("rom_addr_idle", k, int'(addr_w[k]), p_base(k));
                chk("valid", k, int'(valid_w[k]), int'(m_valid[k]));
                chk("data", k, int'(data_w[k]), int'(m_data[k]));
                chk("busy", k, int'(busy_w[k]), int'(m_busy[k]));
                chk("done", k, int'(done_w[k]), int'(m_done[k]));

                if (en_w[k]) begin
                    if (t_first_en[k] < 0) t_first_en[k] = cyc;
                    en_cyc[k][cnt_en[k] % 16] = cyc;
                    cnt_en[k]++;
                end
                if (valid_w[k]) begin
                    if (t_first_v[k] < 0) t_first_v[k] = cyc;
                    t_last_v[k] = cyc;
                    slot[k][cnt_v[k] % 16] = int'(data_w[k]);
                    cnt_v[k]++;
                end
                if (done_w[k]) begin
                    t_done[k] = cyc;
                    cnt_done[k]++;
                end
                if (busy_w[k]) cnt_busy[k]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;

    initial begin
        rst = 1'b1; ce = 1'b1; start = '0;
        clear_trk();
        tick(1);
        chk_on = 1'b1;
        tick(2);
        chk("reset_addr", 0, int'(addr_w[0]), 32'h20);
        chk("reset_busy", 0, int'(busy_w[0]), 0);
        rst = 1'b0;
        tick(2);

        // Basic load
        clear_trk(); t0 = cyc;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(20);
        chk("t1_first_en", 0, t_first_en[0] - t0, 1);
        chk("t1_first_valid", 0, t_first_v[0] - t0, 3);
        chk("t1_done_cycle", 0, t_done[0] - t0, 13);
        chk("t1_valid_count", 0, cnt_v[0], 10);
        chk("t1_busy_cycles", 0, cnt_busy[0], 12);
        for (int i = 0; i < 10; i++) chk("t1_slot", 0, slot[0][i], 100 + i);

        // ce stall on cycles 4..6
        clear_trk(); t0 = cyc;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(3); ce = 1'b0;
        tick(3); ce = 1'b1;
        tick(20);
        chk("t2_third_issue", 0, en_cyc[0][2] - t0, 3);
        chk("t2_resume_issue", 0, en_cyc[0][3] - t0, 7);
        chk("t2_valid_count", 0, cnt_v[0], 10);
        chk("t2_done_cycle", 0, t_done[0] - t0, 16);
        for (int i = 0; i < 10; i++) chk("t2_slot", 0, slot[0][i], 100 + i);

        // RD_LAT=3, SIZE=4
        clear_trk(); t0 = cyc;
        start[1] = 1'b1; tick(1); start[1] = 1'b0;
        tick(20);
        chk("t3_latency", 1, t_first_v[1] - t_first_en[1], 4);
        chk("t3_valid_count", 1, cnt_v[1], 4);
        chk("t3_done_after_last", 1, t_done[1] - t_last_v[1], 1);
        chk("t3_slot0", 1, slot[1][0], -564);
        chk("t3_slot3", 1, slot[1][3], -567);

        // Start while busy (cycle 5) and in DONE (cycle 13) is ignored
        clear_trk(); t0 = cyc;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(4); start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(7); start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(15);
        chk("t4_valid_count", 0, cnt_v[0], 10);
        chk("t4_issue_count", 0, cnt_en[0], 10);
        chk("t4_done_count", 0, cnt_done[0], 1);
        chk("t4_done_cycle", 0, t_done[0] - t0, 13);

        // Reset at cycle 6 aborts the load
        clear_trk(); t0 = cyc;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(5); rst = 1'b1;
        tick(1); rst = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_rst", 0, int'(valid_w[0]), 0);
        chk("t5_en_after_rst", 0, int'(en_w[0]), 0);
        chk("t5_busy_after_rst", 0, int'(busy_w[0]), 0);
        chk("t5_addr_after_rst", 0, int'(addr_w[0]), 32'h20);
        tick(12);
        chk("t5_aborted_valids", 0, cnt_v[0], 4);
        chk("t5_no_done", 0, cnt_done[0], 0);
        clear_trk();
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(20);
        chk("t5_reload_count", 0, cnt_v[0], 10);
        chk("t5_reload_done", 0, cnt_done[0], 1);
        for (int i = 0; i < 10; i++) chk("t5_slot", 0, slot[0][i], 100 + i);

        // SIZE=1
        clear_trk(); t0 = cyc;
        start[2] = 1'b1; tick(1); start[2] = 1'b0;
        tick(10);
        chk("t6_issue_count", 2, cnt_en[2], 1);
        chk("t6_first_en", 2, t_first_en[2] - t0, 1);
        chk("t6_valid_count", 2, cnt_v[2], 1);
        chk("t6_slot0", 2, slot[2][0], -1234);
        chk("t6_done_after_valid", 2, t_done[2] - t_first_v[2], 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/bias_loader.md
Name: bias_loader

Overview:
- Writer side of the bias buffer interface: on a start command, reads SIZE bias words from a fixed-latency bias ROM starting at BASE_ADDR.
- Presents the words one per strobe (o_valid drives the buffer's ce, o_data drives its i_data) so the buffer fills slots 0..SIZE-1 in order.
- Sits between the weight/bias ROM and the per-layer bias buffer.
- Signals busy/done to the layer controller.

Parameters:
- BW, 16, bias word width (signed, two's complement).
- SIZE, 10, number of bias words per load (>=1).
- ADDR_W, 8, ROM address width.
- BASE_ADDR, 0, first ROM address; BASE_ADDR+SIZE-1 must fit in ADDR_W bits.
- RD_LAT, 1, ROM read latency in clk cycles (>=1), from o_rom_en to valid i_rom_data.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- global_rst  input  1  synchronous, active-high reset.
- ce  input  1  issue enable; low pauses new ROM reads only.
- i_start  input  1  load request, sampled in IDLE.
- o_rom_en  output  1  ROM read enable.
- o_rom_addr  output  ADDR_W  ROM read address.
- i_rom_data  input  BW  ROM read data, valid RD_LAT cycles after o_rom_en.
- o_data  output  BW  bias word to buffer.
- o_valid  output  1  one-cycle write strobe per bias word.
- o_busy  output  1  load in progress.
- o_done  output  1  one-cycle pulse, load complete.

Behaviour:
- Reset (global_rst high at a clock edge): state IDLE; issue and return counters cleared; latency shift register cleared.
  - Outputs after reset: o_rom_en=0, o_rom_addr=BASE_ADDR, o_data=0, o_valid=0, o_busy=0, o_done=0.
  - Reset mid-load aborts it: no further o_valid and no o_done.
  - In-flight ROM data is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 and ce=1 -> ISSUE; o_busy=1 from the next cycle.
  - i_start with ce=0 is ignored.
- ISSUE:
  - Each cycle with ce=1: o_rom_en=1, o_rom_addr=BASE_ADDR+issue_cnt, issue_cnt++.
  - ce=0: o_rom_en=0, address and counter hold.
  - After the issue with issue_cnt==SIZE-1 -> DRAIN.
  - First o_rom_en is asserted in the cycle after i_start is accepted.
- Return path:
  - RD_LAT-deep shift register of o_rom_en.
  - When its tail is 1, register o_data<=i_rom_data and assert o_valid=1 for one cycle; ret_cnt++.
  - Latency from o_rom_en to o_valid is RD_LAT+1 cycles; word order equals address order.
  - The return path is not gated by ce; in-flight reads always complete.
  - o_data holds its last value when o_valid=0.
- DRAIN: wait until ret_cnt==SIZE -> DONE.
- DONE:
  - o_done=1 for exactly one cycle, in the cycle after the last o_valid; o_busy=0 in the same cycle.
  - Next state IDLE.
- i_start while o_busy=1 or in DONE is ignored, with no queuing.
- Exactly SIZE o_valid pulses per accepted start; never more, even if ce toggles.
- Counter width is clog2(SIZE+1).
- SIZE=1: one read; ISSUE lasts one enabled cycle, then DRAIN.
- o_rom_addr returns to BASE_ADDR in IDLE.

Decomposition:
- Shared package/include holds the clog2 function (existing param_clog2.vh) and the FSM state encodings (2-bit localparams).
- One natural sub-module: bias_rd_pipe, the RD_LAT-deep valid shift register with synchronous clear.
- Counters and FSM stay in the top level.

Test Plan:
1. Basic load, SIZE=10, BASE_ADDR=0x20, RD_LAT=1, ROM[a]=a-0x20+100, ce=1, start pulse at cycle 0:
   - addresses 0x20..0x29 on cycles 1..10;
   - o_valid on cycles 3..12 with o_data 100..109;
   - o_done on cycle 13; o_busy high on cycles 1..12.
   - A bias buffer attached to the outputs ends with slots 0..9 = 100..109.
2. ce stall: same setup, ce=0 on cycles 4..6:
   - address issue pauses at 0x23 and resumes at cycle 7;
   - exactly 10 o_valid pulses, in order;
   - o_done occurs 3 cycles later than in test 1.
3. Latency, RD_LAT=3, SIZE=4: first o_valid arrives 4 cycles after the first o_rom_en; 4 pulses total; o_done the cycle after the last pulse.
4. Start during busy: second i_start at cycle 5 of test 1 -> ignored; total still 10 pulses and one o_done.
5. Reset mid-load: global_rst high at cycle 6:
   - next cycle o_valid=0, o_rom_en=0, o_busy=0, o_rom_addr=BASE_ADDR;
   - no o_done;
   - a subsequent start performs a complete 10-word load.
6. Edge, SIZE=1: start -> one read at BASE_ADDR, one o_valid with ROM[BASE_ADDR], o_done the following cycle.
